block_dispatcher: RTL
=====================

BLOCK_DISPATCHER -- requirements
Module: block_dispatcher

Interface
REQ-001 Parameter NUM_CU, default 2: number of block-level control units served.
REQ-002 Parameter IDX_W, default 4: width of each block row/column index.
REQ-003 i_Clock  in  1: single clock; all state changes on its rising edge.
REQ-004 i_Reset_n  in  1: reset, synchronous, active-low.
REQ-005 i_Start  in  1: one-cycle request to begin a product; sampled only in S_IDLE.
REQ-006 i_Block_Rows  in  IDX_W: number of block rows of C; sampled with i_Start.
REQ-007 i_Block_Cols  in  IDX_W: number of block columns of C; sampled with i_Start.
REQ-008 o_Indexes_Ready  out  NUM_CU: per-CU offer valid.
REQ-009 o_Row_Index  out  NUM_CU*IDX_W: per-CU block row i; CU c uses slice [c*IDX_W +: IDX_W].
REQ-010 o_Column_Index  out  NUM_CU*IDX_W: per-CU block column j; same slicing.
REQ-011 i_Indexes_Received  in  NUM_CU: per-CU acknowledge of an offer.
REQ-012 i_Result_Ready  in  NUM_CU: per-CU completion of the C_ij block write.
REQ-013 o_Busy  out  1: high in every state except S_IDLE.
REQ-014 o_Done  out  1: one-cycle pulse when the whole product is complete.
REQ-015 o_Blocks_Done  out  2*IDX_W: count of completed blocks in the current run.

Function
REQ-016 States: S_IDLE, S_DISPATCH, S_DRAIN, S_DONE; registered outputs only.
REQ-017 S_IDLE + i_Start=1: latch rows/cols, clear cursor (i=0, j=0), clear o_Blocks_Done, clear busy mask; go to S_DISPATCH, or to S_DONE if rows=0 or cols=0.
REQ-018 Dispatch order row-major: (0,0),(0,1)..(0,cols-1),(1,0)..(rows-1,cols-1); j wraps to 0 with i+1.
REQ-019 At most one offer outstanding at any time across all CUs.
REQ-020 In S_DISPATCH, with no offer outstanding and an idle CU, the next edge raises o_Indexes_Ready[c] for the lowest-numbered idle CU c, driving its index slices with the cursor.
REQ-021 An offer, with its indexes, is held unchanged until i_Indexes_Received[c] is sampled high.
REQ-022 On the edge sampling acknowledge: clear o_Indexes_Ready[c], set busy[c], advance the cursor; the next offer is raised no earlier than the following edge (min 2 cycles between offers).
REQ-023 i_Indexes_Received[c] without an outstanding offer to c is ignored.
REQ-024 i_Result_Ready[c] with busy[c]=1: clear busy[c], increment o_Blocks_Done; with busy[c]=0: ignored.
REQ-025 A CU freed by i_Result_Ready at edge t may be offered at edge t+1 at earliest.
REQ-026 Multiple i_Result_Ready bits in one cycle all retire in that cycle; o_Blocks_Done increases by their count.
REQ-027 After acknowledge of the last block (rows-1, cols-1): go to S_DRAIN.
REQ-028 S_DRAIN -> S_DONE when busy mask is all zero (checked after that edge's retirements).
REQ-029 S_DONE lasts exactly one cycle with o_Done=1, then S_IDLE; o_Blocks_Done holds until next i_Start.
REQ-030 i_Start outside S_IDLE is ignored.
REQ-031 Arithmetic: cursor and count modulo widths stated; total blocks rows*cols fits 2*IDX_W.

Reset
REQ-032 i_Reset_n=0 at an edge, in any state including mid-run: state S_IDLE, o_Indexes_Ready=0, index outputs=0, busy mask=0, o_Busy=0, o_Done=0, o_Blocks_Done=0; outstanding offers and busy CUs are abandoned.

Verification
REQ-033 rows=2, cols=2, NUM_CU=2, CUs ack 1 cycle after offer and finish 10 cycles later -> offers (0,0)->CU0, (0,1)->CU1, (1,0),(1,1) to freed CUs in order; o_Done single pulse; o_Blocks_Done=4.
REQ-034 rows=0, cols=3, i_Start -> S_DONE next cycle, o_Done pulse, no o_Indexes_Ready ever high, o_Blocks_Done=0.
REQ-035 Offer to CU0 with ack delayed 5 cycles -> o_Indexes_Ready[0] and indexes stable all 5 cycles; no offer to CU1 meanwhile.
REQ-036 rows=1, cols=3, CU1 result_ready pulse while idle, and CU0/CU1 result_ready in same cycle -> spurious pulse ignored; count increments by 2 on the simultaneous cycle; final count 3.
REQ-037 i_Reset_n low during S_DRAIN with both CUs busy -> next cycle all outputs at reset values; later i_Start rows=1, cols=1 completes normally with count 1.
REQ-038 i_Start pulsed during S_DISPATCH -> no effect on cursor, count or sequence.

Source files
------------

// File: rtl/block_dispatcher.sv
// ---------------------------------------------------------------------------
// block_dispatcher
//   Hands out the (row, column) block coordinates of a blocked matrix product
//   C = A*B to a pool of block-level control units (CUs) in row-major order,
//   tracks which CUs are working, counts retired blocks and reports when the
//   whole product is complete.
//
// Parameters
//   NUM_CU  number of control units served
//   IDX_W   width of a block row / column index
//
// Ports
//   i_Clock             clock, rising edge active
//   i_Reset_n           synchronous active-low reset
//   i_Start             request to begin a product (sampled only in S_IDLE)
//   i_Block_Rows/Cols   block dimensions of C, sampled with i_Start
//   o_Indexes_Ready     per-CU offer valid (at most one bit set)
//   o_Row_Index         per-CU block row, CU c at [c*IDX_W +: IDX_W]
//   o_Column_Index      per-CU block column, same slicing
//   i_Indexes_Received  per-CU acknowledge of an offer
//   i_Result_Ready      per-CU completion of its block
//   o_Busy              high whenever the dispatcher is not idle
//   o_Done              one-cycle pulse at completion of the product
//   o_Blocks_Done       number of blocks retired in the current run
// ---------------------------------------------------------------------------
module block_dispatcher #(
    parameter int NUM_CU = 2,
    parameter int IDX_W  = 4
) (
    input  logic                    i_Clock,
    input  logic                    i_Reset_n,
    input  logic                    i_Start,
    input  logic [IDX_W-1:0]        i_Block_Rows,
    input  logic [IDX_W-1:0]        i_Block_Cols,
    output logic [NUM_CU-1:0]       o_Indexes_Ready,
    output logic [NUM_CU*IDX_W-1:0] o_Row_Index,
    output logic [NUM_CU*IDX_W-1:0] o_Column_Index,
    input  logic [NUM_CU-1:0]       i_Indexes_Received,
    input  logic [NUM_CU-1:0]       i_Result_Ready,
    output logic                    o_Busy,
    output logic                    o_Done,
    output logic [2*IDX_W-1:0]      o_Blocks_Done
);

    localparam int CNT_W = 2 * IDX_W;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DISPATCH = 2'd1,
        S_DRAIN    = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    state_t                    state_r, state_s;
    logic [IDX_W-1:0]          rows_r, rows_s;
    logic [IDX_W-1:0]          cols_r, cols_s;
    logic [IDX_W-1:0]          cur_i_r, cur_i_s;
    logic [IDX_W-1:0]          cur_j_r, cur_j_s;
    logic [NUM_CU-1:0]         busy_r, busy_s;
    logic [NUM_CU-1:0]         ready_s;
    logic [NUM_CU*IDX_W-1:0]   row_idx_s;
    logic [NUM_CU*IDX_W-1:0]   col_idx_s;
    logic [CNT_W-1:0]          count_s;
    logic [NUM_CU-1:0]         idle_s;
    logic [NUM_CU-1:0]         pick_s;
    logic [NUM_CU-1:0]         retire_s;
    logic                      last_s;

    // Number of set bits in a CU mask, sized to the block counter.
    function automatic logic [CNT_W-1:0] count_ones(input logic [NUM_CU-1:0] mask);
        logic [CNT_W-1:0] cnt;
        cnt = {CNT_W{1'b0}};
        for (int k = 0; k < NUM_CU; k++) begin
            cnt = cnt + CNT_W'(mask[k]);
        end
        return cnt;
    endfunction

    // Candidate selection and retirement masks derived from the current busy set.
    always_comb begin
        idle_s   = ~busy_r;
        // Isolate the lowest set bit: lowest-numbered idle CU wins.
        pick_s   = idle_s & (~idle_s + NUM_CU'(1'b1));
        // A completion only counts for a CU that actually holds a block.
        retire_s = i_Result_Ready & busy_r;
        last_s   = (cur_i_r == (rows_r - IDX_W'(1'b1))) &&
                   (cur_j_r == (cols_r - IDX_W'(1'b1)));
    end

    // Next-state and next-output computation for the dispatcher FSM.
    always_comb begin
        state_s   = state_r;
        rows_s    = rows_r;
        cols_s    = cols_r;
        cur_i_s   = cur_i_r;
        cur_j_s   = cur_j_r;
        busy_s    = busy_r;
        ready_s   = o_Indexes_Ready;
        row_idx_s = o_Row_Index;
        col_idx_s = o_Column_Index;
        count_s   = o_Blocks_Done;

        case (state_r)
            S_IDLE: begin
                if (i_Start) begin
                    rows_s  = i_Block_Rows;
                    cols_s  = i_Block_Cols;
                    cur_i_s = {IDX_W{1'b0}};
                    cur_j_s = {IDX_W{1'b0}};
                    busy_s  = {NUM_CU{1'b0}};
                    count_s = {CNT_W{1'b0}};
                    if ((i_Block_Rows == {IDX_W{1'b0}}) || (i_Block_Cols == {IDX_W{1'b0}})) begin
                        state_s = S_DONE;
                    end else begin
                        state_s = S_DISPATCH;
                    end
                end else begin
                    state_s = S_IDLE;
                end
            end

            S_DISPATCH: begin
                busy_s  = busy_r & ~retire_s;
                count_s = o_Blocks_Done + count_ones(retire_s);
                if (|o_Indexes_Ready) begin
                    // Offer outstanding: hold it until the addressed CU acknowledges.
                    if (|(o_Indexes_Ready & i_Indexes_Received)) begin
                        ready_s = {NUM_CU{1'b0}};
                        busy_s  = busy_s | o_Indexes_Ready;
                        if (cur_j_r == (cols_r - IDX_W'(1'b1))) begin
                            cur_j_s = {IDX_W{1'b0}};
                            cur_i_s = cur_i_r + IDX_W'(1'b1);
                        end else begin
                            cur_j_s = cur_j_r + IDX_W'(1'b1);
                        end
                        if (last_s) begin
                            state_s = S_DRAIN;
                        end else begin
                            state_s = S_DISPATCH;
                        end
                    end else begin
                        state_s = S_DISPATCH;
                    end
                end else if (|pick_s) begin
                    // Offer uses pre-retirement busy, so a CU freed this edge waits one cycle.
                    ready_s = pick_s;
                    for (int c = 0; c < NUM_CU; c++) begin
                        if (pick_s[c]) begin
                            row_idx_s[c*IDX_W +: IDX_W] = cur_i_r;
                            col_idx_s[c*IDX_W +: IDX_W] = cur_j_r;
                        end else begin
                            row_idx_s[c*IDX_W +: IDX_W] = o_Row_Index[c*IDX_W +: IDX_W];
                            col_idx_s[c*IDX_W +: IDX_W] = o_Column_Index[c*IDX_W +: IDX_W];
                        end
                    end
                end else begin
                    state_s = S_DISPATCH;
                end
            end

            S_DRAIN: begin
                busy_s  = busy_r & ~retire_s;
                count_s = o_Blocks_Done + count_ones(retire_s);
                if (busy_s == {NUM_CU{1'b0}}) begin
                    state_s = S_DONE;
                end else begin
                    state_s = S_DRAIN;
                end
            end

            S_DONE: begin
                state_s = S_IDLE;
            end

            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // State and registered-output update with synchronous active-low reset.
    always_ff @(posedge i_Clock) begin
        if (!i_Reset_n) begin
            state_r         <= S_IDLE;
            rows_r          <= {IDX_W{1'b0}};
            cols_r          <= {IDX_W{1'b0}};
            cur_i_r         <= {IDX_W{1'b0}};
            cur_j_r         <= {IDX_W{1'b0}};
            busy_r          <= {NUM_CU{1'b0}};
            o_Indexes_Ready <= {NUM_CU{1'b0}};
            o_Row_Index     <= {(NUM_CU*IDX_W){1'b0}};
            o_Column_Index  <= {(NUM_CU*IDX_W){1'b0}};
            o_Blocks_Done   <= {CNT_W{1'b0}};
            o_Busy          <= 1'b0;
            o_Done          <= 1'b0;
        end else begin
            state_r         <= state_s;
            rows_r          <= rows_s;
            cols_r          <= cols_s;
            cur_i_r         <= cur_i_s;
            cur_j_r         <= cur_j_s;
            busy_r          <= busy_s;
            o_Indexes_Ready <= ready_s;
            o_Row_Index     <= row_idx_s;
            o_Column_Index  <= col_idx_s;
            o_Blocks_Done   <= count_s;
            o_Busy          <= (state_s != S_IDLE);
            o_Done          <= (state_s == S_DONE);
        end
    end

endmodule
